// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the receive-side frame parser.
package rx_frame_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHK
  } state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/rx_byte_fifo.sv
// First-word-fall-through payload FIFO; a push while full is accepted only
// when a pop frees a slot in the same cycle.
module rx_byte_fifo
  import rx_frame_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  fifo_entry_t wdata,
  output fifo_entry_t rdata,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t     r_mem [DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic            w_do_pop;
  logic            w_do_push;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign rdata     = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rx_frame_parser.sv
// Sync-hunting frame parser: validates LEN and XOR checksum, forwards payload
// through a FWFT FIFO and reports per-frame status and diagnostics.
module rx_frame_parser
  import rx_frame_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_LEN    = 15
) (
  input  logic       clk_rec,
  input  logic       resetn_rec,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic [7:0] m_data_o,
  output logic       m_last_o,
  output logic       m_valid_o,
  input  logic       m_ready_i,
  output logic       frame_ok_o,
  output logic       frame_err_o,
  output logic       overflow_o,
  input  logic       clr_ovf_i,
  output logic [7:0] err_cnt_o
);

  localparam logic [7:0] LP_MAX_LEN = 8'(MAX_LEN);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_len;
  logic [7:0]  r_cnt;
  logic [7:0]  r_acc;
  logic        r_frame_ovf;
  logic        r_frame_ok;
  logic        r_frame_err;
  logic        r_overflow;
  logic [7:0]  r_err_cnt;

  logic        w_push;
  logic        w_last;
  logic        w_len_ok;
  logic        w_ok_set;
  logic        w_err_set;
  logic        w_pop;
  logic        w_drop;
  logic        w_full;
  logic        w_empty;
  fifo_entry_t w_wr_entry;
  fifo_entry_t w_rd_entry;

  always_ff @(posedge clk_rec or negedge resetn_rec) begin
    if (!resetn_rec) r_state <= HUNT;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_last      = 1'b0;
    w_len_ok    = 1'b0;
    w_ok_set    = 1'b0;
    w_err_set   = 1'b0;
    if (valid_i) begin
      unique case (r_state)
        HUNT: begin
          if (data_i == SYNC_BYTE) w_state_nxt = LEN;
        end
        LEN: begin
          if (data_i == 8'd0 || data_i > LP_MAX_LEN) begin
            w_err_set   = 1'b1;
            w_state_nxt = HUNT;
          end else begin
            w_len_ok    = 1'b1;
            w_state_nxt = PAYLOAD;
          end
        end
        PAYLOAD: begin
          w_push = 1'b1;
          w_last = (r_cnt == r_len - 8'd1);
          if (w_last) w_state_nxt = CHK;
        end
        CHK: begin
          if (data_i == r_acc && !r_frame_ovf) w_ok_set  = 1'b1;
          else                                 w_err_set = 1'b1;
          w_state_nxt = HUNT;
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  assign w_pop      = m_valid_o && m_ready_i;
  // A byte is lost only when the FIFO is full and no pop frees a slot this cycle.
  assign w_drop     = w_push && w_full && !w_pop;
  assign w_wr_entry = '{last: w_last, data: data_i};

  always_ff @(posedge clk_rec or negedge resetn_rec) begin
    if (!resetn_rec) begin
      r_len       <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_frame_ovf <= 1'b0;
    end else if (w_len_ok) begin
      r_len       <= data_i;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_frame_ovf <= 1'b0;
    end else if (w_push) begin
      r_cnt <= r_cnt + 8'd1;
      r_acc <= r_acc ^ data_i;
      if (w_drop) r_frame_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk_rec or negedge resetn_rec) begin
    if (!resetn_rec) begin
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_frame_ok  <= w_ok_set;
      r_frame_err <= w_err_set;
      if (w_err_set && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      if (w_drop)         r_overflow <= 1'b1;
      else if (clr_ovf_i) r_overflow <= 1'b0;
    end
  end

  rx_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_rec),
    .rst_n (resetn_rec),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wr_entry),
    .rdata (w_rd_entry),
    .full  (w_full),
    .empty (w_empty)
  );

  // Storage is unreset, so the read port is masked to keep outputs 0 when empty.
  assign m_valid_o   = !w_empty;
  assign m_data_o    = w_empty ? 8'h00 : w_rd_entry.data;
  assign m_last_o    = w_empty ? 1'b0  : w_rd_entry.last;
  assign frame_ok_o  = r_frame_ok;
  assign frame_err_o = r_frame_err;
  assign overflow_o  = r_overflow;
  assign err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_rx_frame_parser.sv
// Directed and randomized checks of rx_frame_parser against a frame-level model.
module tb_rx_frame_parser;

  localparam int FIFO_DEPTH = 16;
  localparam int MAX_LEN    = 15;

  logic       clk_rec = 1'b0;
  logic       resetn_rec;
  logic [7:0] data_i;
  logic       valid_i;
  logic [7:0] m_data_o;
  logic       m_last_o;
  logic       m_valid_o;
  logic       m_ready_i;
  logic       frame_ok_o;
  logic       frame_err_o;
  logic       overflow_o;
  logic       clr_ovf_i;
  logic [7:0] err_cnt_o;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  logic [7:0] stim[$];
  logic [8:0] exp_pay[$];
  logic [8:0] got_q[$];
  logic       exp_st[$];
  logic       st_q[$];

  rx_frame_parser #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_LEN    (MAX_LEN)
  ) dut (
    .clk_rec     (clk_rec),
    .resetn_rec  (resetn_rec),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .m_data_o    (m_data_o),
    .m_last_o    (m_last_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .frame_ok_o  (frame_ok_o),
    .frame_err_o (frame_err_o),
    .overflow_o  (overflow_o),
    .clr_ovf_i   (clr_ovf_i),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk_rec = ~clk_rec;

  // Consumer side: record accepted bytes and every cycle a status pulse is high.
  always @(negedge clk_rec) begin
    if (resetn_rec) begin
      if (m_valid_o && m_ready_i) got_q.push_back({m_last_o, m_data_o});
      if (frame_ok_o)  st_q.push_back(1'b1);
      if (frame_err_o) st_q.push_back(1'b0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_rec);
    #1;
  endtask

  // Frame-level reference: scan the byte stream, at most cap payload bytes fit.
  task automatic model(input int cap);
    int i = 0;
    int stored = 0;
    int len;
    logic [7:0] x;
    logic ovf;
    while (i < stim.size()) begin
      if (stim[i] != 8'hA5) begin
        i++;
        continue;
      end
      if (i + 1 >= stim.size()) break;
      len = int'(stim[i+1]);
      if (len == 0 || len > MAX_LEN) begin
        exp_st.push_back(1'b0);
        i += 2;
        continue;
      end
      if (i + 2 + len >= stim.size()) break;
      x = 8'h00;
      ovf = 1'b0;
      for (int k = 0; k < len; k++) begin
        x ^= stim[i+2+k];
        if (stored < cap) begin
          exp_pay.push_back({(k == len - 1), stim[i+2+k]});
          stored++;
        end else begin
          ovf = 1'b1;
        end
      end
      exp_st.push_back((stim[i+2+len] == x) && !ovf);
      i += len + 3;
    end
    foreach (exp_st[j]) if (!exp_st[j] && exp_err < 255) exp_err++;
  endtask

  task automatic clear_queues();
    stim.delete();
    exp_pay.delete();
    got_q.delete();
    exp_st.delete();
    st_q.delete();
  endtask

  task automatic send_stim(input int maxgap);
    foreach (stim[i]) begin
      repeat ($urandom_range(0, maxgap)) tick();
      data_i  = stim[i];
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      data_i  = 8'h00;
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, "_npay"}, got_q.size(), exp_pay.size());
    for (int i = 0; i < exp_pay.size() && i < got_q.size(); i++)
      chk({tag, "_pay"}, 32'(got_q[i]), 32'(exp_pay[i]));
    chk({tag, "_nst"}, st_q.size(), exp_st.size());
    for (int i = 0; i < exp_st.size() && i < st_q.size(); i++)
      chk({tag, "_st"}, 32'(st_q[i]), 32'(exp_st[i]));
    chk({tag, "_errcnt"}, 32'(err_cnt_o), exp_err);
  endtask

  task automatic run_case(input string tag, input int maxgap);
    send_stim(maxgap);
    repeat (30) tick();
    model(1 << 30);
    compare(tag);
  endtask

  task automatic add_frame(input int len, input logic good);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    stim.push_back(8'hA5);
    stim.push_back(8'(len));
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom);
      x ^= b;
      stim.push_back(b);
    end
    stim.push_back(good ? x : (x ^ 8'(1 + $urandom_range(0, 254))));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(m_valid_o), 0);
    chk({tag, "_data"},  32'(m_data_o), 0);
    chk({tag, "_last"},  32'(m_last_o), 0);
    chk({tag, "_ok"},    32'(frame_ok_o), 0);
    chk({tag, "_err"},   32'(frame_err_o), 0);
    chk({tag, "_ovf"},   32'(overflow_o), 0);
    chk({tag, "_cnt"},   32'(err_cnt_o), 0);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] first;
    int kind;

    resetn_rec = 1'b0;
    data_i     = 8'h00;
    valid_i    = 1'b0;
    m_ready_i  = 1'b1;
    clr_ovf_i  = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    resetn_rec = 1'b1;
    tick();

    clear_queues();
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
    run_case("good3", 0);

    clear_queues();
    stim = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00};
    run_case("badchk", 0);

    clear_queues();
    stim = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h01, 8'h7E, 8'h7E};
    run_case("gaps", 3);

    clear_queues();
    stim = '{8'hA5, 8'h00, 8'hA5, 8'h10, 8'hA5, 8'h01, 8'h42, 8'h42};
    run_case("badlen", 1);

    clear_queues();
    for (int f = 0; f < 12; f++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: add_frame($urandom_range(1, MAX_LEN), 1'b1);
        1: add_frame($urandom_range(1, MAX_LEN), 1'b0);
        2: begin
          stim.push_back(8'hA5);
          stim.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
        end
        default: begin
          do b = 8'($urandom); while (b == 8'hA5);
          stim.push_back(b);
        end
      endcase
    end
    run_case("random", 2);

    clear_queues();
    m_ready_i = 1'b0;
    add_frame(15, 1'b1);
    add_frame(15, 1'b1);
    first = stim[2];
    send_stim(0);
    repeat (3) tick();
    chk("ovf_set", 32'(overflow_o), 1);
    chk("ovf_hold_valid", 32'(m_valid_o), 1);
    chk("ovf_hold_data", 32'(m_data_o), 32'(first));
    chk("ovf_hold_last", 32'(m_last_o), 0);
    m_ready_i = 1'b1;
    repeat (30) tick();
    model(FIFO_DEPTH);
    compare("ovf");
    chk("ovf_sticky", 32'(overflow_o), 1);
    clr_ovf_i = 1'b1;
    tick();
    clr_ovf_i = 1'b0;
    chk("ovf_clr", 32'(overflow_o), 0);

    clear_queues();
    stim = '{8'hA5, 8'h04, 8'h01, 8'h02};
    send_stim(0);
    #2;
    resetn_rec = 1'b0;
    #1;
    check_idle_outputs("midrst");
    st_q.delete();
    got_q.delete();
    repeat (3) tick();
    chk("midrst_nopulse", st_q.size(), 0);
    resetn_rec = 1'b1;
    exp_err = 0;
    tick();
    clear_queues();
    stim = '{8'hA5, 8'h01, 8'h55, 8'h55};
    run_case("postrst", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
